// File: rtl/uart_axi_pkg.sv
// Shared types and constants for the UART-command-to-AXI4-Lite master.
package uart_axi_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_AXI_WR,
        ST_AXI_B,
        ST_AXI_AR,
        ST_AXI_R,
        ST_SEND
    } state_t;

    // Command bytes from the host.
    localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD = 8'h52;  // 'R'

    // Reply bytes to the host.
    localparam logic [7:0] RSP_OK  = 8'h4B; // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45; // 'E'
    localparam logic [7:0] RSP_BAD = 8'h3F; // '?'

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Map an AXI response code onto the single status byte sent back.
    function automatic logic [7:0] status_byte(input logic [1:0] resp);
        return (resp == AXI_RESP_OKAY) ? RSP_OK : RSP_ERR;
    endfunction

endpackage

// File: rtl/uart_axi_txbuf.sv
// Reply shift buffer: loads 1 or 5 bytes and drains them MSB first
// through a valid/ready byte handshake. done pulses (combinationally)
// in the cycle whose handshake consumes the last byte.
module uart_axi_txbuf
    import uart_axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        load_five,
    input  logic [39:0] load_bytes,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);

    logic [7:0]  data_reg;
    logic        valid_reg;
    logic [31:0] shift_reg;   // bytes still queued behind data_reg
    logic [2:0]  remain_reg;  // number of bytes queued behind data_reg

    // Load a new reply, or advance to the next byte on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg   <= 8'h00;
            valid_reg  <= 1'b0;
            shift_reg  <= 32'h0;
            remain_reg <= 3'd0;
        end else if (load) begin
            data_reg   <= load_bytes[39:32];
            shift_reg  <= load_bytes[31:0];
            remain_reg <= load_five ? 3'd4 : 3'd0;
            valid_reg  <= 1'b1;
        end else if (valid_reg && tx_ready) begin
            if (remain_reg == 3'd0) begin
                valid_reg <= 1'b0;
            end else begin
                data_reg   <= shift_reg[31:24];
                shift_reg  <= {shift_reg[23:0], 8'h00};
                remain_reg <= remain_reg - 3'd1;
            end
        end
    end

    assign tx_data  = data_reg;
    assign tx_valid = valid_reg;
    assign done     = valid_reg && tx_ready && (remain_reg == 3'd0);

endmodule

// File: rtl/uart_axi_master.sv
// UART command frame parser driving single-beat AXI4-Lite reads/writes.
// Every output is a register; next values are computed in one
// combinational process from the next state.
module uart_axi_master
    import uart_axi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              busy
);

    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(RX_TIMEOUT - 1);

    state_t         state_reg, state_next;
    logic [1:0]     byte_cnt_reg, byte_cnt_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [31:0]    addr_reg, addr_next;
    logic [31:0]    data_reg, data_next;
    logic           is_write_reg, is_write_next;
    logic           awvalid_reg, awvalid_next;
    logic           wvalid_reg, wvalid_next;
    logic           arvalid_reg, arvalid_next;
    logic           rx_ready_reg, bready_reg, rready_reg, busy_reg;

    logic           accept;
    logic           aw_pending, w_pending;
    logic           tx_load, tx_five, tx_done;
    logic [39:0]    tx_bytes;

    assign accept = rx_valid && rx_ready_reg;

    // Next-state, datapath and reply-load decisions.
    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        timer_next    = timer_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        is_write_next = is_write_reg;
        awvalid_next  = awvalid_reg;
        wvalid_next   = wvalid_reg;
        arvalid_next  = arvalid_reg;
        aw_pending    = 1'b0;
        w_pending     = 1'b0;
        tx_load       = 1'b0;
        tx_five       = 1'b0;
        tx_bytes      = 40'h0;

        case (state_reg)
            ST_IDLE: begin
                timer_next    = '0;
                byte_cnt_next = 2'd0;
                if (accept) begin
                    if (rx_data == CMD_WR) begin
                        is_write_next = 1'b1;
                        state_next    = ST_GET_ADDR;
                    end else if (rx_data == CMD_RD) begin
                        is_write_next = 1'b0;
                        state_next    = ST_GET_ADDR;
                    end else begin
                        tx_load    = 1'b1;
                        tx_bytes   = {RSP_BAD, 32'h0};
                        state_next = ST_SEND;
                    end
                end
            end

            ST_GET_ADDR: begin
                if (accept) begin
                    addr_next     = {addr_reg[23:0], rx_data};
                    timer_next    = '0;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        if (is_write_reg) begin
                            state_next = ST_GET_DATA;
                        end else begin
                            arvalid_next = 1'b1;
                            state_next   = ST_AXI_AR;
                        end
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_GET_DATA: begin
                if (accept) begin
                    data_next     = {data_reg[23:0], rx_data};
                    timer_next    = '0;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = ST_AXI_WR;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_AXI_WR: begin
                // Each channel retires on its own handshake.
                aw_pending   = awvalid_reg && !m_axi_awready;
                w_pending    = wvalid_reg && !m_axi_wready;
                awvalid_next = aw_pending;
                wvalid_next  = w_pending;
                if (!aw_pending && !w_pending) begin
                    state_next = ST_AXI_B;
                end
            end

            ST_AXI_B: begin
                if (m_axi_bvalid && bready_reg) begin
                    tx_load    = 1'b1;
                    tx_bytes   = {status_byte(m_axi_bresp), 32'h0};
                    state_next = ST_SEND;
                end
            end

            ST_AXI_AR: begin
                if (m_axi_arready) begin
                    arvalid_next = 1'b0;
                    state_next   = ST_AXI_R;
                end
            end

            ST_AXI_R: begin
                if (m_axi_rvalid && rready_reg) begin
                    tx_load = 1'b1;
                    if (m_axi_rresp == AXI_RESP_OKAY) begin
                        tx_five  = 1'b1;
                        tx_bytes = {RSP_OK, m_axi_rdata};
                    end else begin
                        tx_bytes = {RSP_ERR, 32'h0};
                    end
                    state_next = ST_SEND;
                end
            end

            ST_SEND: begin
                if (tx_done) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops every valid at once.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= 2'd0;
            timer_reg    <= '0;
            addr_reg     <= 32'h0;
            data_reg     <= 32'h0;
            is_write_reg <= 1'b0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            arvalid_reg  <= 1'b0;
            rx_ready_reg <= 1'b0;
            bready_reg   <= 1'b0;
            rready_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            timer_reg    <= timer_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            is_write_reg <= is_write_next;
            awvalid_reg  <= awvalid_next;
            wvalid_reg   <= wvalid_next;
            arvalid_reg  <= arvalid_next;
            rx_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_GET_ADDR) ||
                            (state_next == ST_GET_DATA);
            bready_reg   <= (state_next == ST_AXI_B);
            rready_reg   <= (state_next == ST_AXI_R);
            busy_reg     <= (state_next != ST_IDLE);
        end
    end

    uart_axi_txbuf u_txbuf (
        .clk        (m_axi_aclk),
        .rst_n      (m_axi_aresetn),
        .load       (tx_load),
        .load_five  (tx_five),
        .load_bytes (tx_bytes),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .done       (tx_done)
    );

    assign rx_ready      = rx_ready_reg;
    assign m_axi_awaddr  = addr_reg[ADDR_W-1:0];
    assign m_axi_araddr  = addr_reg[ADDR_W-1:0];
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = data_reg;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_rready  = rready_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_uart_axi_master.sv
// Directed bench for uart_axi_master: inputs change on the falling edge,
// outputs are sampled on the falling edge, slave is driven step by step.
module tb_uart_axi_master;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] awaddr, araddr, wdata, rdata = 32'h0;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic        rvalid = 1'b0, rready, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_axi_master #(.ADDR_W(32), .RX_TIMEOUT(TO)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one byte and return at the falling edge after it is taken.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rx_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("rx_accept", {63'h0, ok}, 64'h1);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    endtask

    // Wait for a reply byte, take it with a one-cycle tx_ready.
    task automatic recv_byte(output logic [7:0] b);
        bit ok;
        ok = 1'b0;
        b  = 8'hxx;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (tx_valid === 1'b1) begin
                b  = tx_data;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("tx_avail", {63'h0, ok}, 64'h1);
        if (ok) begin
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    // Zero-wait read slave: accept the address, then return one beat.
    task automatic slave_read(input logic [31:0] d, input logic [1:0] r);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("ar_drop", {63'h0, arvalid}, 64'h0);
        chk("rready", {63'h0, rready}, 64'h1);
        rdata  = d;
        rresp  = r;
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
    endtask

    task automatic expect_read_ok(input string tag, input logic [31:0] d);
        logic [7:0] b;
        logic [39:0] exp;
        exp = {8'h4B, d};
        for (int i = 4; i >= 0; i--) begin
            recv_byte(b);
            chk(tag, {56'h0, b}, {56'h0, exp[i*8 +: 8]});
        end
    endtask

    logic [7:0] rb;
    logic       activity;

    initial begin
        // Reset state.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_rx_ready", {63'h0, rx_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_valids", {60'h0, awvalid, wvalid, arvalid, tx_valid}, 64'h0);
        chk("rst_readys", {62'h0, bready, rready}, 64'h0);
        chk("rst_wstrb", {60'h0, wstrb}, 64'hF);
        chk("rst_addr", {awaddr, wdata}, 64'h0);
        chk("rst_tx_data", {56'h0, tx_data}, 64'h0);
        rst_n = 1'b1;
        tick();
        chk("rx_ready_up", {63'h0, rx_ready}, 64'h1);

        // Write 0x28B to 0x10, zero-wait slave, OKAY.
        send_frame(8'h57, 32'h0000_0010);
        for (int i = 3; i >= 0; i--) begin
            logic [31:0] dw;
            dw = 32'h0000_028B;
            send_byte(dw[i*8 +: 8]);
        end
        chk("wr1_valids", {62'h0, awvalid, wvalid}, 64'h3);
        chk("wr1_awaddr", {32'h0, awaddr}, 64'h10);
        chk("wr1_wdata", {32'h0, wdata}, 64'h28B);
        chk("wr1_wstrb", {60'h0, wstrb}, 64'hF);
        chk("wr1_busy", {63'h0, busy}, 64'h1);
        chk("wr1_rx_ready", {63'h0, rx_ready}, 64'h0);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("wr1_drop", {62'h0, awvalid, wvalid}, 64'h0);
        chk("wr1_bready", {63'h0, bready}, 64'h1);
        bresp = 2'b00; bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("wr1_send", {63'h0, tx_valid}, 64'h1);
        recv_byte(rb);
        chk("wr1_reply", {56'h0, rb}, 64'h4B);
        chk("wr1_idle", {62'h0, busy, rx_ready}, 64'h1);
        $display("write addr=00000010 data=0000028b reply=%02h", rb);

        // Read 0xDEADBEEF from 0x04 with a 10-cycle tx stall mid-reply.
        send_frame(8'h52, 32'h0000_0004);
        chk("rd1_arvalid", {63'h0, arvalid}, 64'h1);
        chk("rd1_araddr", {32'h0, araddr}, 64'h4);
        chk("rd1_no_aw", {62'h0, awvalid, wvalid}, 64'h0);
        slave_read(32'hDEAD_BEEF, 2'b00);
        recv_byte(rb);
        chk("rd1_b0", {56'h0, rb}, 64'h4B);
        recv_byte(rb);
        chk("rd1_b1", {56'h0, rb}, 64'hDE);
        activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_data !== 8'hAD || tx_valid !== 1'b1) activity = 1'b1;
            tick();
        end
        chk("rd1_stall_stable", {63'h0, activity}, 64'h0);
        recv_byte(rb);
        chk("rd1_b2", {56'h0, rb}, 64'hAD);
        recv_byte(rb);
        chk("rd1_b3", {56'h0, rb}, 64'hBE);
        recv_byte(rb);
        chk("rd1_b4", {56'h0, rb}, 64'hEF);
        chk("rd1_done", {62'h0, tx_valid, busy}, 64'h0);
        $display("read addr=00000004 data=deadbeef reply done");

        // Write: wready three cycles ahead of awready, SLVERR response.
        send_frame(8'h57, 32'h0000_0020);
        for (int i = 3; i >= 0; i--) begin
            logic [31:0] dw;
            dw = 32'h1234_5678;
            send_byte(dw[i*8 +: 8]);
        end
        chk("wr2_valids", {62'h0, awvalid, wvalid}, 64'h3);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("wr2_w_drop", {62'h0, awvalid, wvalid}, 64'h2);
        tick();
        tick();
        chk("wr2_aw_held", {31'h0, awvalid, awaddr}, {31'h0, 1'b1, 32'h20});
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("wr2_aw_drop", {62'h0, awvalid, bready}, 64'h1);
        bresp = 2'b10; bvalid = 1'b1;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        recv_byte(rb);
        chk("wr2_reply", {56'h0, rb}, 64'h45);
        $display("write addr=00000020 data=12345678 reply=%02h", rb);

        // Unknown command byte.
        send_byte(8'h41);
        chk("bad_no_axi", {62'h0, awvalid, arvalid}, 64'h0);
        recv_byte(rb);
        chk("bad_reply", {56'h0, rb}, 64'h3F);
        $display("command 41 reply=%02h", rb);

        // Partial frame abandoned by the inter-byte timeout.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("to_busy_partial", {63'h0, busy}, 64'h1);
        activity = 1'b0;
        for (int i = 0; i < TO + 5; i++) begin
            if (awvalid || wvalid || arvalid || tx_valid) activity = 1'b1;
            tick();
        end
        chk("to_no_axi", {63'h0, activity}, 64'h0);
        chk("to_idle", {62'h0, busy, rx_ready}, 64'h1);
        $display("partial frame timed out");

        // Normal read after the timeout.
        send_frame(8'h52, 32'h0000_0008);
        chk("rd2_araddr", {32'h0, araddr}, 64'h8);
        slave_read(32'h0102_0304, 2'b00);
        expect_read_ok("rd2_reply", 32'h0102_0304);
        $display("read addr=00000008 data=01020304 reply done");

        // Read with an error response: single 'E'.
        send_frame(8'h52, 32'h0000_0030);
        slave_read(32'hFFFF_FFFF, 2'b10);
        recv_byte(rb);
        chk("rd3_reply", {56'h0, rb}, 64'h45);
        tick();
        chk("rd3_single", {62'h0, tx_valid, busy}, 64'h0);
        $display("read addr=00000030 reply=%02h", rb);

        // Asynchronous reset during the address phase of a read.
        send_frame(8'h52, 32'h0000_000C);
        chk("rst_ar_before", {63'h0, arvalid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ar_drop", {62'h0, arvalid, busy}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ar_rx_ready", {63'h0, rx_ready}, 64'h1);
        send_frame(8'h52, 32'h0000_000C);
        chk("rd4_araddr", {31'h0, arvalid, araddr}, {31'h0, 1'b1, 32'hC});
        slave_read(32'hCAFE_F00D, 2'b00);
        expect_read_ok("rd4_reply", 32'hCAFE_F00D);
        $display("read addr=0000000c data=cafef00d after reset reply done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
